// File: rtl/pls_cnt_mod.sv
// Modulo-N pulse counter stage for the watch datapath.
// Edge-detects a slow pulse input and counts up or down, wrapping at MODULO.
// Stages chain through plso. The stage supports clear, load (clamped to range)
// and enable.
module pls_cnt_mod #(
  parameter int unsigned MODULO    = 60,
  parameter int unsigned W         = 6,
  parameter int unsigned EDGE_RISE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         plsi,
  input  logic         en,
  input  logic         dn,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         plso,
  output logic [W-1:0] qout
);

  // Largest legal count. It fits in W bits even when MODULO == 2**W.
  localparam logic [W-1:0] MAX_VAL = W'(MODULO - 1);

  // Two-flop history for each level input; the edges are derived from these.
  logic c0, c1, p0, p1;
  logic clr_evt, cnt_evt;

  // Next-state values for the registered outputs.
  logic [W-1:0] q_nxt;
  logic         plso_nxt;

  // Clear acts once per rising edge; the count edge polarity is chosen at build time.
  assign clr_evt = c0 & ~c1;
  assign cnt_evt = (EDGE_RISE != 0) ? (p0 & ~p1) : (p1 & ~p0);

  // Edge history keeps running regardless of en/ld, so no event is queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      c0 <= 1'b0;
      c1 <= 1'b0;
      p0 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      c0 <= clr;
      c1 <= c0;
      p0 <= plsi;
      p1 <= p0;
    end
  end

  // Count register and carry/borrow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= '0;
      plso <= 1'b0;
    end else begin
      qout <= q_nxt;
      plso <= plso_nxt;
    end
  end

  // Priority: clear, then load, then an enabled count step, otherwise hold.
  always_comb begin
    q_nxt    = qout;
    plso_nxt = 1'b0;
    if (clr_evt) begin
      q_nxt = '0;
    end else if (ld) begin
      q_nxt = (ld_val > MAX_VAL) ? MAX_VAL : ld_val;
    end else if (cnt_evt && en) begin
      if (!dn) begin
        if (qout == MAX_VAL) begin
          q_nxt    = '0;
          plso_nxt = 1'b1;
        end else begin
          q_nxt = qout + W'(1);
        end
      end else begin
        if (qout == '0) begin
          q_nxt    = MAX_VAL;
          plso_nxt = 1'b1;
        end else begin
          q_nxt = qout - W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pls_cnt_mod.sv
// Directed self-checking bench for pls_cnt_mod.
// Instance a is the default mod-60 counter on falling edges; instance b is
// mod-24, 5-bit, counting rising edges.
module tb_pls_cnt_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: MODULO=60, W=6, falling edge.
  logic       rst, clr, plsi, en, dn, ld;
  logic [5:0] ld_val;
  logic       plso;
  logic [5:0] qout;

  // Instance b: MODULO=24, W=5, rising edge.
  logic       rst_b, clr_b, plsi_b, en_b, dn_b, ld_b;
  logic [4:0] ld_val_b;
  logic       plso_b;
  logic [4:0] qout_b;

  int n_cmp = 0;
  int n_err = 0;

  pls_cnt_mod #(.MODULO(60), .W(6), .EDGE_RISE(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .plsi(plsi), .en(en), .dn(dn),
    .ld(ld), .ld_val(ld_val), .plso(plso), .qout(qout)
  );

  pls_cnt_mod #(.MODULO(24), .W(5), .EDGE_RISE(1)) dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .plsi(plsi_b), .en(en_b), .dn(dn_b),
    .ld(ld_b), .ld_val(ld_val_b), .plso(plso_b), .qout(qout_b)
  );

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full plsi pulse on instance a; returns just after the edge that applies the falling-edge count.
  task automatic do_fall();
    plsi = 1'b1;
    step(2);
    plsi = 1'b0;
    step(2);
  endtask

  // Load a value into instance a with a single-cycle ld strobe.
  task automatic load_a(input logic [5:0] v);
    ld     = 1'b1;
    ld_val = v;
    step(1);
    ld     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst_b = 1'b1;
    clr = 0; plsi = 0; en = 1; dn = 0; ld = 0; ld_val = '0;
    clr_b = 0; plsi_b = 0; en_b = 1; dn_b = 0; ld_b = 0; ld_val_b = '0;
    step(2);
    rst = 1'b0;
    rst_b = 1'b0;
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL reset_q got %0d want 0", qout); end
    n_cmp++; if (plso !== 1'b0) begin n_err++; $display("FAIL reset_plso got %b want 0", plso); end
    n_cmp++; if (qout_b !== 5'd0) begin n_err++; $display("FAIL reset_q_b got %0d want 0", qout_b); end
    step(3);
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL idle_q got %0d want 0", qout); end
  endtask

  task automatic test_up_wrap();
    dn = 0;
    en = 1;
    for (int i = 1; i <= 60; i++) begin
      do_fall();
      n_cmp++; if (qout !== 6'(i % 60)) begin n_err++; $display("FAIL up_q edge %0d got %0d want %0d", i, qout, i % 60); end
      n_cmp++; if (plso !== (i == 60)) begin n_err++; $display("FAIL up_plso edge %0d got %b want %b", i, plso, (i == 60)); end
      step(1);
      n_cmp++; if (plso !== 1'b0) begin n_err++; $display("FAIL up_plso_width edge %0d got %b want 0", i, plso); end
    end
  endtask

  task automatic test_down_wrap();
    load_a(6'd0);
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL dn_load got %0d want 0", qout); end
    dn = 1;
    do_fall();
    n_cmp++; if (qout !== 6'd59) begin n_err++; $display("FAIL dn_wrap_q got %0d want 59", qout); end
    n_cmp++; if (plso !== 1'b1) begin n_err++; $display("FAIL dn_wrap_plso got %b want 1", plso); end
    step(1);
    n_cmp++; if (plso !== 1'b0) begin n_err++; $display("FAIL dn_plso_width got %b want 0", plso); end
    do_fall();
    n_cmp++; if (qout !== 6'd58) begin n_err++; $display("FAIL dn_step_q got %0d want 58", qout); end
    n_cmp++; if (plso !== 1'b0) begin n_err++; $display("FAIL dn_step_plso got %b want 0", plso); end
    dn = 0;
  endtask

  task automatic test_load_clamp();
    ld = 1'b1;
    ld_val = 6'd63;
    step(1);
    n_cmp++; if (qout !== 6'd59) begin n_err++; $display("FAIL clamp_q got %0d want 59", qout); end
    step(3);
    n_cmp++; if (qout !== 6'd59) begin n_err++; $display("FAIL clamp_hold got %0d want 59", qout); end
    ld = 1'b0;
    do_fall();
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL clamp_cnt_q got %0d want 0", qout); end
    n_cmp++; if (plso !== 1'b1) begin n_err++; $display("FAIL clamp_cnt_plso got %b want 1", plso); end
    // The load arrives on the same edge as a count event; the load wins.
    plsi = 1'b1;
    step(2);
    plsi = 1'b0;
    step(1);
    ld = 1'b1;
    ld_val = 6'd5;
    step(1);
    ld = 1'b0;
    n_cmp++; if (qout !== 6'd5) begin n_err++; $display("FAIL ld_vs_cnt_q got %0d want 5", qout); end
    n_cmp++; if (plso !== 1'b0) begin n_err++; $display("FAIL ld_vs_cnt_plso got %b want 0", plso); end
    step(2);
    n_cmp++; if (qout !== 6'd5) begin n_err++; $display("FAIL ld_cnt_lost got %0d want 5", qout); end
  endtask

  task automatic test_priority();
    load_a(6'd59);
    plsi = 1'b1;
    step(2);
    // clr and plsi change together, so their edges land on the same posedge.
    plsi = 1'b0;
    clr  = 1'b1;
    step(2);
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL clr_vs_cnt_q got %0d want 0", qout); end
    n_cmp++; if (plso !== 1'b0) begin n_err++; $display("FAIL clr_vs_cnt_plso got %b want 0", plso); end
    for (int i = 1; i <= 3; i++) begin
      do_fall();
      n_cmp++; if (qout !== 6'(i)) begin n_err++; $display("FAIL clr_held_q %0d got %0d want %0d", i, qout, i); end
    end
    clr = 1'b0;
    step(2);
    n_cmp++; if (qout !== 6'd3) begin n_err++; $display("FAIL clr_release_q got %0d want 3", qout); end
    clr = 1'b1;
    step(2);
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL clr_again_q got %0d want 0", qout); end
    clr = 1'b0;
    step(2);
  endtask

  task automatic test_enable();
    load_a(6'd12);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_fall();
      n_cmp++; if (qout !== 6'd12) begin n_err++; $display("FAIL en_off_q %0d got %0d want 12", i, qout); end
    end
    en = 1'b1;
    do_fall();
    n_cmp++; if (qout !== 6'd13) begin n_err++; $display("FAIL en_on_q got %0d want 13", qout); end
  endtask

  task automatic test_reset_mid();
    load_a(6'd29);
    do_fall();
    n_cmp++; if (qout !== 6'd30) begin n_err++; $display("FAIL mid_setup_q got %0d want 30", qout); end
    plsi = 1'b1;
    step(2);
    plsi = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL mid_rst_q got %0d want 0", qout); end
    n_cmp++; if (plso !== 1'b0) begin n_err++; $display("FAIL mid_rst_plso got %b want 0", plso); end
    step(3);
    n_cmp++; if (qout !== 6'd0) begin n_err++; $display("FAIL mid_rst_discard got %0d want 0", qout); end
  endtask

  task automatic test_rise_mod24();
    for (int i = 1; i <= 24; i++) begin
      plsi_b = 1'b1;
      step(2);
      n_cmp++; if (qout_b !== 5'(i % 24)) begin n_err++; $display("FAIL b_up_q edge %0d got %0d want %0d", i, qout_b, i % 24); end
      n_cmp++; if (plso_b !== (i == 24)) begin n_err++; $display("FAIL b_up_plso edge %0d got %b want %b", i, plso_b, (i == 24)); end
      plsi_b = 1'b0;
      step(2);
      n_cmp++; if (plso_b !== 1'b0) begin n_err++; $display("FAIL b_plso_width edge %0d got %b want 0", i, plso_b); end
    end
    ld_b = 1'b1;
    ld_val_b = 5'd31;
    step(1);
    ld_b = 1'b0;
    n_cmp++; if (qout_b !== 5'd23) begin n_err++; $display("FAIL b_clamp_q got %0d want 23", qout_b); end
    // Reset released with plsi high: exactly one count two edges after release.
    plsi_b = 1'b1;
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    n_cmp++; if (qout_b !== 5'd0) begin n_err++; $display("FAIL b_rst_q got %0d want 0", qout_b); end
    step(1);
    n_cmp++; if (qout_b !== 5'd0) begin n_err++; $display("FAIL b_rel1_q got %0d want 0", qout_b); end
    step(1);
    n_cmp++; if (qout_b !== 5'd1) begin n_err++; $display("FAIL b_rel2_q got %0d want 1", qout_b); end
    step(3);
    n_cmp++; if (qout_b !== 5'd1) begin n_err++; $display("FAIL b_rel_hold got %0d want 1", qout_b); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_priority();
    test_enable();
    test_reset_mid();
    test_rise_mod24();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
